// File: rtl/valve_program_sequencer.sv
// Valve-bank program sequencer: fetches 13-bit instructions from address 0,
// applies SET/UNSET to a registered valve vector and times DELAYs in ms units.
module valve_program_sequencer #(
    parameter int unsigned ADDR_W   = 8,
    parameter int unsigned TICK_DIV = 100000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [12:0]       imem_data,
    output logic [15:0]       valve_state,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [ADDR_W-1:0] pc
);

    localparam int unsigned PRESC_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int unsigned UNIT_W  = 14;
    localparam int unsigned DLY_W   = 6;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_FETCH = 3'd1;
    localparam logic [2:0] S_EXEC  = 3'd2;
    localparam logic [2:0] S_DELAY = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    localparam logic [2:0] OP_HALT  = 3'd0;
    localparam logic [2:0] OP_SET   = 3'd1;
    localparam logic [2:0] OP_DELAY = 3'd2;

    logic [2:0]         state_q, state_d;
    logic [ADDR_W-1:0]  pc_q, pc_d;
    logic [15:0]        valve_q, valve_d;
    logic               err_q, err_d;
    logic               done_q, done_d;
    logic               busy_q, busy_d;
    logic [PRESC_W-1:0] presc_q, presc_d;
    logic [UNIT_W-1:0]  unit_q, unit_d;
    logic [UNIT_W-1:0]  ulim_q, ulim_d;
    logic [DLY_W-1:0]   dcnt_q, dcnt_d;

    logic [2:0]         opcode;
    logic [3:0]         valve_idx;
    logic               set_bit;
    logic [DLY_W-1:0]   dly;
    logic [2:0]         time_unit;
    logic               dbg;
    logic               at_end;
    logic [ADDR_W-1:0]  pc_inc;
    logic               retire;

    // Last value of the unit counter (unit_ms - 1); debug forces 1 ms units.
    function automatic logic [UNIT_W-1:0] unit_last(input logic [2:0] tu, input logic d);
        logic [UNIT_W-1:0] r;
        if (d) begin
            r = UNIT_W'(0);
        end else begin
            case (tu)
                3'd0:    r = UNIT_W'(0);
                3'd1:    r = UNIT_W'(9);
                3'd2:    r = UNIT_W'(99);
                3'd3:    r = UNIT_W'(999);
                3'd4:    r = UNIT_W'(9999);
                default: r = UNIT_W'(999);
            endcase
        end
        return r;
    endfunction

    assign opcode    = imem_data[12:10];
    assign valve_idx = imem_data[9:6];
    assign set_bit   = imem_data[0];
    assign dly       = imem_data[9:4];
    assign time_unit = imem_data[3:1];
    assign dbg       = imem_data[0];
    assign at_end    = (pc_q == {ADDR_W{1'b1}});
    assign pc_inc    = pc_q + ADDR_W'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            pc_q    <= '0;
            valve_q <= '0;
            err_q   <= 1'b0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
            presc_q <= '0;
            unit_q  <= '0;
            ulim_q  <= '0;
            dcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            valve_q <= valve_d;
            err_q   <= err_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
            presc_q <= presc_d;
            unit_q  <= unit_d;
            ulim_q  <= ulim_d;
            dcnt_q  <= dcnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        valve_d = valve_q;
        err_d   = err_q;
        done_d  = done_q;
        busy_d  = busy_q;
        presc_d = presc_q;
        unit_d  = unit_q;
        ulim_d  = ulim_q;
        dcnt_d  = dcnt_q;
        retire  = 1'b0;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    pc_d    = '0;
                    err_d   = 1'b0;
                    done_d  = 1'b0;
                    busy_d  = 1'b1;
                    state_d = S_FETCH;
                end
            end
            S_FETCH: state_d = S_EXEC;
            S_EXEC: begin
                retire = 1'b1;
                case (opcode)
                    OP_HALT: begin
                        retire  = 1'b0;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        state_d = S_DONE;
                    end
                    OP_SET: valve_d[valve_idx] = set_bit;
                    OP_DELAY: begin
                        // A nonzero delay at the last address is dropped; the run ends in error.
                        if (dly != '0 && !at_end) begin
                            retire  = 1'b0;
                            dcnt_d  = dly;
                            presc_d = '0;
                            unit_d  = '0;
                            ulim_d  = unit_last(time_unit, dbg);
                            state_d = S_DELAY;
                        end
                    end
                    default: err_d = 1'b1;
                endcase
                if (retire) begin
                    if (at_end) begin
                        err_d   = 1'b1;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        state_d = S_DONE;
                    end else begin
                        pc_d    = pc_inc;
                        state_d = S_FETCH;
                    end
                end
            end
            S_DELAY: begin
                // Prescaler -> unit counter -> delay down-counter cascade.
                if (presc_q == PRESC_W'(TICK_DIV - 1)) begin
                    presc_d = '0;
                    if (unit_q == ulim_q) begin
                        unit_d = '0;
                        dcnt_d = dcnt_q - DLY_W'(1);
                        if (dcnt_q == DLY_W'(1)) begin
                            pc_d    = pc_inc;
                            state_d = S_FETCH;
                        end
                    end else begin
                        unit_d = unit_q + UNIT_W'(1);
                    end
                end else begin
                    presc_d = presc_q + PRESC_W'(1);
                end
            end
            default: begin
                busy_d  = 1'b0;
                done_d  = 1'b0;
                state_d = S_IDLE;
            end
        endcase

        if (abort) begin
            state_d = S_IDLE;
            pc_d    = '0;
            valve_d = '0;
            err_d   = 1'b0;
            done_d  = 1'b0;
            busy_d  = 1'b0;
            presc_d = '0;
            unit_d  = '0;
            ulim_d  = '0;
            dcnt_d  = '0;
        end
    end

    assign imem_addr   = pc_q;
    assign pc          = pc_q;
    assign valve_state = valve_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign err         = err_q;

endmodule

// File: tb/tb_valve_program_sequencer.sv
// Bench for valve_program_sequencer: directed programs plus random programs
// checked against an instruction-level reference model.
module tb_valve_program_sequencer;

    localparam int TICK   = 4;
    localparam int BUDGET = 5000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start_a, abort_a, start_b, abort_b;
    logic [7:0]  addr_a, pc_a;
    logic [1:0]  addr_b, pc_b;
    logic [12:0] data_a, data_b;
    logic [15:0] valve_a, valve_b;
    logic        busy_a, done_a, err_a, busy_b, done_b, err_b;

    logic [12:0] mem_a [256];
    logic [12:0] mem_b [4];

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    always @(posedge clk) data_a <= mem_a[addr_a];
    always @(posedge clk) data_b <= mem_b[addr_b];

    valve_program_sequencer #(.ADDR_W(8), .TICK_DIV(TICK)) dut_a (
        .clk(clk), .rst_n(rst_n), .start(start_a), .abort(abort_a),
        .imem_addr(addr_a), .imem_data(data_a), .valve_state(valve_a),
        .busy(busy_a), .done(done_a), .err(err_a), .pc(pc_a));

    valve_program_sequencer #(.ADDR_W(2), .TICK_DIV(TICK)) dut_b (
        .clk(clk), .rst_n(rst_n), .start(start_b), .abort(abort_b),
        .imem_addr(addr_b), .imem_data(data_b), .valve_state(valve_b),
        .busy(busy_b), .done(done_b), .err(err_b), .pc(pc_b));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int unit_ms(input logic [12:0] w);
        if (w[0]) return 1;
        case (w[3:1])
            3'd0: return 1;
            3'd1: return 10;
            3'd2: return 100;
            3'd3: return 1000;
            3'd4: return 10000;
            default: return 1000;
        endcase
    endfunction

    // Instruction-level model: returns cycles from the start edge until done is seen.
    function automatic int model(input int aw, input logic [15:0] v_in,
                                 output logic [15:0] v, output logic e, output int pc_o);
        int maxpc = (1 << aw) - 1;
        int p = 0;
        int cyc = 0;
        logic [12:0] w;
        v = v_in;
        e = 1'b0;
        for (int k = 0; k < 300; k++) begin
            w = (aw == 2) ? mem_b[p] : mem_a[p];
            cyc += 2;
            if (w[12:10] == 3'd0) break;
            if (w[12:10] == 3'd1) v[w[9:6]] = w[0];
            else if (w[12:10] == 3'd2) begin
                if (w[9:4] != 0 && p != maxpc) cyc += int'(w[9:4]) * unit_ms(w) * TICK;
            end else e = 1'b1;
            if (p == maxpc) begin
                e = 1'b1;
                break;
            end
            p++;
        end
        pc_o = p;
        return cyc;
    endfunction

    task automatic clear_mem();
        for (int i = 0; i < 256; i++) mem_a[i] = 13'h0000;
    endtask

    task automatic step_a(inout int n);
        @(posedge clk);
        #1;
        n++;
    endtask

    task automatic pulse_start_a();
        start_a = 1'b1;
        @(posedge clk);
        #1;
        start_a = 1'b0;
    endtask

    task automatic wait_done_a(inout int n);
        while (!done_a && n < BUDGET) step_a(n);
    endtask

    task automatic run_check_a(input string tag, inout logic [15:0] vstate);
        logic [15:0] ev;
        logic        ee;
        int          ep, ec, n;
        ec = model(8, vstate, ev, ee, ep);
        pulse_start_a();
        n = 0;
        check({tag, "_done_clr"}, 32'(done_a), 32'(0));
        wait_done_a(n);
        check({tag, "_cycles"}, 32'(n), 32'(ec));
        check({tag, "_valve"}, 32'(valve_a), 32'(ev));
        check({tag, "_err"}, 32'(err_a), 32'(ee));
        check({tag, "_pc"}, 32'(pc_a), 32'(ep));
        check({tag, "_busy"}, 32'(busy_a), 32'(0));
        vstate = ev;
    endtask

    logic [15:0] exp_v;
    int          n;
    logic [12:0] w;

    initial begin
        rst_n = 1'b0;
        start_a = 1'b0; abort_a = 1'b0; start_b = 1'b0; abort_b = 1'b0;
        clear_mem();
        for (int i = 0; i < 4; i++) mem_b[i] = 13'h04C1;
        exp_v = 16'h0;
        #12;
        check("rst_valve", 32'(valve_a), 32'(0));
        check("rst_flags", {29'(0), busy_a, done_a, err_a}, 32'(0));
        check("rst_pc", 32'(pc_a), 32'(0));
        #10;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // SET v3 then HALT
        mem_a[0] = 13'h04C1; mem_a[1] = 13'h0000;
        pulse_start_a();
        n = 0;
        step_a(n); step_a(n);
        check("t1_valve_at2", 32'(valve_a), 32'h0008);
        wait_done_a(n);
        check("t1_done_at4", 32'(n), 32'(4));
        check("t1_pc", 32'(pc_a), 32'(1));
        check("t1_busy", 32'(busy_a), 32'(0));
        exp_v = 16'h0008;

        // DELAY 5 in three unit settings: 2 + 5*unit*TICK + 2 cycles
        mem_a[0] = 13'h0850;
        pulse_start_a(); n = 0; wait_done_a(n);
        check("t2_unit1", 32'(n), 32'(24));
        mem_a[0] = 13'h0852;
        pulse_start_a(); n = 0; wait_done_a(n);
        check("t2_unit10", 32'(n), 32'(204));
        mem_a[0] = 13'h0857;
        pulse_start_a(); n = 0; wait_done_a(n);
        check("t2_debug", 32'(n), 32'(24));
        check("t2_valve_kept", 32'(valve_a), 32'h0008);

        // abort clears valves, then illegal opcode program
        abort_a = 1'b1; @(posedge clk); #1; abort_a = 1'b0;
        check("t3_abort_valve", 32'(valve_a), 32'(0));
        exp_v = 16'h0;
        mem_a[0] = 13'h1C00; mem_a[1] = 13'h0441; mem_a[2] = 13'h0000;
        pulse_start_a(); n = 0;
        step_a(n); step_a(n);
        check("t3_err_early", 32'(err_a), 32'(1));
        wait_done_a(n);
        check("t3_cycles", 32'(n), 32'(6));
        check("t3_valve", 32'(valve_a), 32'h0002);
        check("t3_done", 32'(done_a), 32'(1));
        exp_v = 16'h0002;

        // abort (with simultaneous start) 10 cycles into a DELAY
        mem_a[0] = 13'h07C1; mem_a[1] = 13'h08F0; mem_a[2] = 13'h0000;
        pulse_start_a(); n = 0;
        while (n < 14) step_a(n);
        check("t4_busy_in_delay", 32'(busy_a), 32'(1));
        abort_a = 1'b1; start_a = 1'b1;
        @(posedge clk); #1;
        abort_a = 1'b0; start_a = 1'b0;
        check("t4_abort_valve", 32'(valve_a), 32'(0));
        check("t4_abort_flags", {29'(0), busy_a, done_a, err_a}, 32'(0));
        check("t4_abort_pc", 32'(pc_a), 32'(0));
        exp_v = 16'h0;
        run_check_a("t4_rerun", exp_v);

        // zero-length DELAY
        mem_a[0] = 13'h0800; mem_a[1] = 13'h0401; mem_a[2] = 13'h0000;
        pulse_start_a(); n = 0; wait_done_a(n);
        check("t5_cycles", 32'(n), 32'(6));
        check("t5_valve", 32'(valve_a), 32'(exp_v | 16'h0001));
        exp_v = exp_v | 16'h0001;

        // end of memory on the 4-word instance, with a start while busy
        start_b = 1'b1; @(posedge clk); #1; start_b = 1'b0;
        n = 0;
        repeat (2) begin @(posedge clk); #1; n++; end
        start_b = 1'b1; @(posedge clk); #1; start_b = 1'b0; n++;
        while (!done_b && n < BUDGET) begin @(posedge clk); #1; n++; end
        check("t6_cycles", 32'(n), 32'(8));
        check("t6_err", 32'(err_b), 32'(1));
        check("t6_pc", 32'(pc_b), 32'(3));
        check("t6_valve", 32'(valve_b), 32'h0008);
        @(posedge clk); #1;
        check("t6_no_wrap", {28'(0), done_b, 1'b0, pc_b}, {28'(0), 1'b1, 1'b0, 2'd3});

        // random programs
        for (int r = 0; r < 10; r++) begin
            int len;
            clear_mem();
            len = $urandom_range(1, 6);
            for (int i = 0; i < len; i++) begin
                case ($urandom_range(0, 2))
                    0: w = {3'd1, 4'($urandom_range(0, 15)), 5'($urandom), 1'($urandom)};
                    1: begin
                        if ($urandom_range(0, 1) == 1)
                            w = {3'd2, 6'($urandom_range(0, 6)), 3'($urandom_range(0, 1)), 1'b0};
                        else
                            w = {3'd2, 6'($urandom_range(0, 6)), 3'($urandom), 1'b1};
                    end
                    default: w = {3'($urandom_range(3, 7)), 10'($urandom)};
                endcase
                mem_a[i] = w;
            end
            run_check_a($sformatf("rnd%0d", r), exp_v);
        end

        // asynchronous reset while mid-program
        mem_a[0] = 13'h0800; mem_a[1] = 13'h0401; mem_a[2] = 13'h0000;
        pulse_start_a(); n = 0;
        while (n < 3) step_a(n);
        #2;
        rst_n = 1'b0;
        #1;
        check("t5_rst_valve", 32'(valve_a), 32'(0));
        check("t5_rst_flags", {29'(0), busy_a, done_a, err_a}, 32'(0));
        check("t5_rst_pc", 32'(pc_a), 32'(0));
        check("t5_rst_b", {12'(0), valve_b, busy_b, done_b, err_b, pc_b}, 32'(0));
        #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        exp_v = 16'h0;
        run_check_a("t5_after_rst", exp_v);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
